pattern_chain_pipe: RTL

Parametrised successor to the fixed merged-pattern netlists. It chains `STAGES` identical pattern cells, each `WIDTH` lanes wide, into a registered pipeline with valid/ready flow control. Each stage holds a per-lane toggle-state register. The tail keeps a transfer counter and an optional signature register. It sits between pattern generators and the grammar-checker back end, replacing hand-merged two-pattern netlists.

---
 rtl/pattern_chain_pkg.sv | 25 ++
 rtl/pattern_chain_stage.sv | 53 +++++
 rtl/pattern_chain_pipe.sv | 88 ++++++++
 3 files changed

// File: rtl/pattern_chain_pkg.sv
// Shared types and cell function for the pattern chain pipeline.
package pattern_chain_pkg;

  localparam int unsigned DEF_WIDTH   = 4;
  localparam int unsigned DEF_STAGES  = 2;
  localparam int unsigned DEF_COUNT_W = 16;

  typedef struct packed {
    logic a;
    logic b;
    logic c;
    logic d;
  } lane_t;

  // One lane of the pattern cell; s is the lane's toggle state before the update.
  function automatic lane_t cell_fn(input lane_t x, input logic s);
    lane_t y;
    y.a = ~(x.a & ~x.b);
    y.b = ~(x.c & ~(x.d | ~x.b));
    y.c = ~x.d;
    y.d = s ^ x.d;
    return y;
  endfunction

endpackage

// File: rtl/pattern_chain_stage.sv
// One pipeline stage: per-lane pattern cell, data/toggle-state registers, valid bit.
module pattern_chain_stage
  import pattern_chain_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              up_valid,
  output logic              up_ready_c,
  input  lane_t [WIDTH-1:0] up_data,
  output logic              dn_valid,
  input  logic              dn_ready,
  output lane_t [WIDTH-1:0] dn_data
);

  logic              valid_q;
  lane_t [WIDTH-1:0] data_q;
  logic  [WIDTH-1:0] state_q;
  lane_t [WIDTH-1:0] cell_c;
  logic  [WIDTH-1:0] state_next_c;
  logic              adv_c;

  assign up_ready_c = ~valid_q | dn_ready;
  assign adv_c      = up_valid & up_ready_c;
  assign dn_valid   = valid_q;
  assign dn_data    = data_q;

  // The stored nd is the post-toggle state, so it doubles as the next state.
  always_comb begin
    cell_c       = '0;
    state_next_c = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      cell_c[i]       = cell_fn(up_data[i], state_q[i]);
      state_next_c[i] = cell_c[i].d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      state_q <= '0;
    end else if (adv_c) begin
      valid_q <= 1'b1;
      data_q  <= cell_c;
      state_q <= state_next_c;
    end else if (dn_ready) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/pattern_chain_pipe.sv
// Chain of STAGES pattern cells with valid/ready flow, transfer counter and
// optional output signature (PATTERN_CHAIN_MISR_EN).
module pattern_chain_pipe
  import pattern_chain_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned STAGES  = DEF_STAGES,
  parameter int unsigned COUNT_W = DEF_COUNT_W
) (
  input  logic               blif_clk_net,
  input  logic               blif_reset_net,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic [WIDTH-1:0]   in_c,
  input  logic [WIDTH-1:0]   in_d,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_a,
  output logic [WIDTH-1:0]   out_b,
  output logic [WIDTH-1:0]   out_c,
  output logic [WIDTH-1:0]   out_d,
  output logic [COUNT_W-1:0] out_count,
  output logic [4*WIDTH-1:0] out_sig
);

  logic [STAGES:0]   vld;
  logic [STAGES:0]   rdy;
  lane_t [WIDTH-1:0] bus [STAGES+1];
  logic              out_fire_c;

  assign vld[0]      = in_valid;
  assign in_ready    = rdy[0];
  assign rdy[STAGES] = out_ready;
  assign out_valid   = vld[STAGES];
  assign out_fire_c  = out_valid & out_ready;

  // Lane-wise repacking between the flat buses and the bundle array.
  genvar i;
  for (i = 0; i < int'(WIDTH); i++) begin : g_lane
    assign bus[0][i] = {in_a[i], in_b[i], in_c[i], in_d[i]};
    assign out_a[i]  = bus[STAGES][i].a;
    assign out_b[i]  = bus[STAGES][i].b;
    assign out_c[i]  = bus[STAGES][i].c;
    assign out_d[i]  = bus[STAGES][i].d;
  end

  genvar k;
  for (k = 0; k < int'(STAGES); k++) begin : g_stage
    pattern_chain_stage #(.WIDTH(WIDTH)) u_stage (
      .clk        (blif_clk_net),
      .rst_n      (blif_reset_net),
      .up_valid   (vld[k]),
      .up_ready_c (rdy[k]),
      .up_data    (bus[k]),
      .dn_valid   (vld[k+1]),
      .dn_ready   (rdy[k+1]),
      .dn_data    (bus[k+1])
    );
  end

  always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
    if (!blif_reset_net) begin
      out_count <= '0;
    end else if (out_fire_c) begin
      out_count <= out_count + COUNT_W'(1);
    end
  end

`ifdef PATTERN_CHAIN_MISR_EN
  localparam int unsigned SIG_W = 4 * WIDTH;
  logic [SIG_W-1:0] sig_q;

  always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
    if (!blif_reset_net) begin
      sig_q <= '0;
    end else if (out_fire_c) begin
      sig_q <= {sig_q[SIG_W-2:0], sig_q[SIG_W-1]} ^ {out_d, out_c, out_b, out_a};
    end
  end

  assign out_sig = sig_q;
`else
  assign out_sig = '0;
`endif

endmodule
